// File: rtl/uart_apb_fifo_regs.sv
// APB register front-end for a UART core: TX/RX FIFOs, control/status, CPB and IRQ.
// The core sees a simple valid/ready TX stream and a valid-only RX push.

module uart_apb_fifo_sync #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  cnt
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [CNT_W-1:0]  cnt_q;

    // Callers gate push with not-full and pop with not-empty on pre-cycle occupancy.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)  rptr_q <= rptr_q + PTR_W'(1);
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wdata;
    end

    assign rdata = mem_q[rptr_q];
    assign cnt   = cnt_q;
endmodule

module uart_apb_fifo_regs #(
    parameter int          DATA_W     = 8,
    parameter int          FIFO_DEPTH = 16,
    parameter int unsigned CPB_RESET  = 217
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [31:0]       PADDR,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [31:0]       cpb,
    output logic              tx_en,
    output logic              rx_en,
    output logic              irq
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [4:0] A_STATUS = 5'h00;
    localparam logic [4:0] A_TDR    = 5'h04;
    localparam logic [4:0] A_RDR    = 5'h08;
    localparam logic [4:0] A_CPB    = 5'h0C;
    localparam logic [4:0] A_CTRL   = 5'h10;
    localparam logic [4:0] A_CLR    = 5'h14;

    logic [31:0]       prdata_q, prdata_d, rd_mux;
    logic [31:0]       cpb_q, cpb_d;
    logic [4:0]        ctrl_q, ctrl_d;
    logic              ovr_q, ovr_d;
    logic              irq_q, irq_d;

    logic [4:0]        addr;
    logic              setup, access, mapped, err, ok;
    logic              tx_push, tx_pop, tx_flush, rx_push, rx_pop, rx_flush, rx_ovr;
    logic              ctrl_we, cpb_we, clr_we;
    logic [CNT_W-1:0]  tx_cnt, rx_cnt;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [DATA_W-1:0] rx_head;
    logic              unused_paddr;

    assign addr         = PADDR[4:0];
    assign unused_paddr = ^PADDR[31:5];
    assign setup        = PSEL & ~PENABLE;
    assign access       = PSEL & PENABLE;

    assign tx_full  = (tx_cnt == CNT_W'(FIFO_DEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == CNT_W'(FIFO_DEPTH));
    assign rx_empty = (rx_cnt == '0);

    assign mapped = (addr == A_STATUS) || (addr == A_TDR) || (addr == A_RDR) ||
                    (addr == A_CPB) || (addr == A_CTRL) || (addr == A_CLR);

    // Errors are judged on the access cycle, against the same occupancy the push/pop uses.
    assign err = ~mapped
               | ( PWRITE & ((addr == A_STATUS) || (addr == A_RDR)))
               | ( PWRITE & (addr == A_TDR) & tx_full)
               | (~PWRITE & (addr == A_RDR) & rx_empty);

    assign ok      = access & ~err & ~PRESET;
    assign PSLVERR = access & err & ~PRESET;
    assign PREADY  = 1'b1;

    assign tx_push  = ok &  PWRITE & (addr == A_TDR);
    assign rx_pop   = ok & ~PWRITE & (addr == A_RDR);
    assign cpb_we   = ok &  PWRITE & (addr == A_CPB);
    assign ctrl_we  = ok &  PWRITE & (addr == A_CTRL);
    assign clr_we   = ok &  PWRITE & (addr == A_CLR);
    assign tx_flush = clr_we & PWDATA[1];
    assign rx_flush = clr_we & PWDATA[2];

    assign tx_valid = ctrl_q[0] & ~tx_empty;
    assign tx_pop   = tx_valid & tx_ready;
    assign rx_push  = rx_valid & ctrl_q[1] & ~rx_full;
    assign rx_ovr   = rx_valid & ctrl_q[1] &  rx_full;

    uart_apb_fifo_sync #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
        .clk(PCLK), .rst(PRESET), .flush(tx_flush), .push(tx_push), .pop(tx_pop),
        .wdata(PWDATA[DATA_W-1:0]), .rdata(tx_data), .cnt(tx_cnt)
    );

    uart_apb_fifo_sync #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_rx_fifo (
        .clk(PCLK), .rst(PRESET), .flush(rx_flush), .push(rx_push), .pop(rx_pop),
        .wdata(rx_data), .rdata(rx_head), .cnt(rx_cnt)
    );

    always_comb begin
        rd_mux = '0;
        case (addr)
            A_STATUS: rd_mux = {8'h0, 8'(rx_cnt), 8'(tx_cnt), 3'b0,
                                ovr_q, rx_full, ~rx_empty, tx_full, tx_empty};
            A_RDR:    rd_mux = rx_empty ? 32'h0 : 32'(rx_head);
            A_CPB:    rd_mux = cpb_q;
            A_CTRL:   rd_mux = 32'(ctrl_q);
            default:  rd_mux = '0;
        endcase
    end

    always_comb begin
        prdata_d = (setup & ~PWRITE) ? rd_mux : 32'h0;
        cpb_d    = cpb_we  ? PWDATA      : cpb_q;
        ctrl_d   = ctrl_we ? PWDATA[4:0] : ctrl_q;
        ovr_d    = ovr_q;
        if (clr_we && PWDATA[0]) ovr_d = 1'b0;
        if (rx_ovr)              ovr_d = 1'b1;  // a same-cycle overrun beats the clear
        irq_d    = (ctrl_q[2] & tx_empty) | (ctrl_q[3] & ~rx_empty) | (ctrl_q[4] & ovr_q);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            prdata_q <= '0;
            cpb_q    <= 32'(CPB_RESET);
            ctrl_q   <= '0;
            ovr_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            prdata_q <= prdata_d;
            cpb_q    <= cpb_d;
            ctrl_q   <= ctrl_d;
            ovr_q    <= ovr_d;
            irq_q    <= irq_d;
        end
    end

    assign PRDATA = prdata_q;
    assign cpb    = cpb_q;
    assign tx_en  = ctrl_q[0];
    assign rx_en  = ctrl_q[1];
    assign irq    = irq_q;
endmodule

// File: tb/tb_uart_apb_fifo_regs.sv
// Randomized bench for uart_apb_fifo_regs against a queue-based register/FIFO model.

module tb_uart_apb_fifo_regs;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic        PCLK = 1'b0;
    logic        PRESET, PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA, cpb;
    logic        PREADY, PSLVERR;
    logic [DW-1:0] tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, tx_en, rx_en, irq;

    int checks = 0;
    int failures = 0;

    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic       ovr_m;
    logic [4:0] ctrl_m;

    uart_apb_fifo_regs #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CPB_RESET(217)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .cpb(cpb), .tx_en(tx_en), .rx_en(rx_en),
        .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // One full APB transfer; samples PRDATA/PSLVERR mid access cycle.
    task automatic apb(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic perr);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        tick();
        PENABLE = 1'b1;
        #1;
        rdata = PRDATA;
        perr  = PSLVERR;
        @(posedge PCLK);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    function automatic logic [31:0] exp_status();
        return {8'h0, 8'(rxq.size()), 8'(txq.size()), 3'b0, ovr_m,
                rxq.size() == DEPTH, rxq.size() != 0, txq.size() == DEPTH, txq.size() == 0};
    endfunction

    function automatic logic exp_irq();
        return (ctrl_m[2] && txq.size() == 0) || (ctrl_m[3] && rxq.size() != 0) ||
               (ctrl_m[4] && ovr_m);
    endfunction

    task automatic model_reset();
        txq.delete(); rxq.delete(); ovr_m = 1'b0; ctrl_m = '0;
    endtask

    task automatic core_push(input logic [7:0] d);
        rx_valid = 1'b1; rx_data = d;
        tick();
        rx_valid = 1'b0;
        if (ctrl_m[1]) begin
            if (rxq.size() < DEPTH) rxq.push_back(d);
            else ovr_m = 1'b1;
        end
    endtask

    task automatic core_pop();
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        if (ctrl_m[0] && txq.size() > 0) void'(txq.pop_front());
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er;
        PRESET = 1'b1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
        tx_ready = 0; rx_valid = 0; rx_data = 0;
        tick(); tick();
        PRESET = 1'b0;
        model_reset();
        checks++;
        if (PRDATA !== 32'h0 || PSLVERR !== 1'b0 || irq !== 1'b0 || tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs prdata=%h slverr=%b irq=%b txv=%b required 0", PRDATA, PSLVERR, irq, tx_valid);
        end
        apb(32'h00, 0, 0, rd, er);
        checks++;
        if (rd !== 32'h1 || er !== 1'b0) begin
            failures++; $display("FAIL reset_status got=%h err=%b required=00000001 err=0", rd, er);
        end
        apb(32'h0C, 0, 0, rd, er);
        checks++;
        if (rd !== 32'd217 || er !== 1'b0 || cpb !== 32'd217) begin
            failures++; $display("FAIL reset_cpb got=%h cpb=%h err=%b required=000000d9", rd, cpb, er);
        end
        checks++;
        if (PRDATA !== 32'h0) begin
            failures++; $display("FAIL prdata_idle got=%h required=0", PRDATA);
        end
    endtask

    task automatic test_tx_basic();
        logic [31:0] rd; logic er;
        apb(32'h10, 1, 32'h1, rd, er); ctrl_m = 5'h1;
        apb(32'h04, 1, 32'hA5, rd, er); txq.push_back(8'hA5);
        apb(32'h04, 1, 32'h3C, rd, er); txq.push_back(8'h3C);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5 || tx_en !== 1'b1) begin
            failures++; $display("FAIL tx_head valid=%b data=%h en=%b required 1/a5/1", tx_valid, tx_data, tx_en);
        end
        apb(32'h00, 0, 0, rd, er);
        checks++;
        if (rd !== exp_status()) begin
            failures++; $display("FAIL tx_status got=%h required=%h", rd, exp_status());
        end
        core_pop();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h3C) begin
            failures++; $display("FAIL tx_pop_next valid=%b data=%h required 1/3c", tx_valid, tx_data);
        end
        core_pop();
        checks++;
        if (tx_valid !== 1'b0) begin
            failures++; $display("FAIL tx_drained valid=%b required 0", tx_valid);
        end
        apb(32'h10, 1, 32'h0, rd, er); ctrl_m = 5'h0;
    endtask

    task automatic test_tx_full();
        logic [31:0] rd; logic er; logic [7:0] d;
        int errs = 0;
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'($urandom);
            apb(32'h04, 1, {24'($urandom), d}, rd, er);
            txq.push_back(d);
            if (er) errs++;
        end
        checks++;
        if (errs != 0) begin
            failures++; $display("FAIL tx_fill_err got=%0d errors required=0", errs);
        end
        apb(32'h04, 1, 32'h77, rd, er);
        checks++;
        if (er !== 1'b1) begin
            failures++; $display("FAIL tx_overflow_slverr got=%b required=1", er);
        end
        apb(32'h00, 0, 0, rd, er);
        checks++;
        if (rd !== exp_status() || tx_valid !== 1'b0 || tx_data !== txq[0]) begin
            failures++; $display("FAIL tx_full_status got=%h required=%h head=%h/%h", rd, exp_status(), tx_data, txq[0]);
        end
        apb(32'h14, 1, 32'h2, rd, er); txq.delete();
        apb(32'h00, 0, 0, rd, er);
        checks++;
        if (rd !== exp_status() || rd[0] !== 1'b1) begin
            failures++; $display("FAIL tx_flush got=%h required=%h", rd, exp_status());
        end
    endtask

    task automatic test_rx_overrun();
        logic [31:0] rd; logic er; logic [7:0] exp_d;
        apb(32'h10, 1, 32'h12, rd, er); ctrl_m = 5'h12;
        for (int i = 0; i < DEPTH + 1; i++) core_push(8'($urandom));
        checks++;
        if (irq !== 1'b0) begin
            failures++; $display("FAIL irq_latency got=%b required=0", irq);
        end
        tick();
        checks++;
        if (irq !== 1'b1 || ovr_m !== 1'b1) begin
            failures++; $display("FAIL irq_ovr got=%b required=1", irq);
        end
        apb(32'h00, 0, 0, rd, er);
        checks++;
        if (rd !== exp_status()) begin
            failures++; $display("FAIL rx_full_status got=%h required=%h", rd, exp_status());
        end
        for (int i = 0; i < DEPTH; i++) begin
            exp_d = rxq.pop_front();
            apb(32'h08, 0, 0, rd, er);
            checks++;
            if (rd !== {24'h0, exp_d} || er !== 1'b0) begin
                failures++; $display("FAIL rdr_read_%0d got=%h err=%b required=%h", i, rd, er, exp_d);
            end
        end
        apb(32'h08, 0, 0, rd, er);
        checks++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            failures++; $display("FAIL rdr_empty got=%h err=%b required=0 err=1", rd, er);
        end
        apb(32'h14, 1, 32'h1, rd, er); ovr_m = 1'b0;
        apb(32'h00, 0, 0, rd, er);
        checks++;
        if (rd !== exp_status()) begin
            failures++; $display("FAIL ovr_clear got=%h required=%h", rd, exp_status());
        end
    endtask

    task automatic test_clr_race();
        logic [31:0] rd; logic er;
        for (int i = 0; i < DEPTH; i++) core_push(8'($urandom));
        rx_valid = 1'b1; rx_data = 8'hEE;
        apb(32'h14, 1, 32'h1, rd, er);
        rx_valid = 1'b0; ovr_m = 1'b1;
        apb(32'h00, 0, 0, rd, er);
        checks++;
        if (rd !== exp_status() || rd[4] !== 1'b1) begin
            failures++; $display("FAIL clr_race_ovr got=%h required=%h", rd, exp_status());
        end
        apb(32'h14, 1, 32'h1, rd, er); ovr_m = 1'b0;
        checks++;
        if (irq !== 1'b1) begin
            failures++; $display("FAIL irq_hold got=%b required=1", irq);
        end
        tick();
        checks++;
        if (irq !== 1'b0) begin
            failures++; $display("FAIL irq_fall got=%b required=0", irq);
        end
        apb(32'h00, 0, 0, rd, er);
        checks++;
        if (rd !== exp_status()) begin
            failures++; $display("FAIL clr_status got=%h required=%h", rd, exp_status());
        end
        apb(32'h14, 1, 32'h4, rd, er); rxq.delete();
        apb(32'h10, 1, 32'h0, rd, er); ctrl_m = 5'h0;
    endtask

    task automatic test_misc_regs();
        logic [31:0] rd; logic er;
        apb(32'h1C, 0, 0, rd, er);
        checks++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            failures++; $display("FAIL unmapped_read got=%h err=%b required=0 err=1", rd, er);
        end
        apb(32'h0C, 1, 32'h364, rd, er);
        checks++;
        if (cpb !== 32'h364 || er !== 1'b0) begin
            failures++; $display("FAIL cpb_write got=%h err=%b required=00000364", cpb, er);
        end
        apb(32'h00, 1, 32'hFF, rd, er);
        checks++;
        if (er !== 1'b1) begin
            failures++; $display("FAIL status_write_err got=%b required=1", er);
        end
        apb(32'h04, 0, 0, rd, er);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            failures++; $display("FAIL tdr_read got=%h err=%b required=0 err=0", rd, er);
        end
        apb(32'h10, 1, 32'hFFFF_FFE3, rd, er); ctrl_m = 5'h03;
        apb(32'h10, 0, 0, rd, er);
        checks++;
        if (rd !== 32'h3 || tx_en !== 1'b1 || rx_en !== 1'b1) begin
            failures++; $display("FAIL ctrl_rw got=%h en=%b%b required=00000003", rd, rx_en, tx_en);
        end
        apb(32'h10, 1, 32'h0, rd, er); ctrl_m = 5'h0;
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h04; PWDATA = 32'h5A;
        tick();
        PENABLE = 1'b1; PRESET = 1'b1;
        tick();
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        model_reset();
        apb(32'h00, 0, 0, rd, er);
        checks++;
        if (rd !== 32'h1 || er !== 1'b0 || cpb !== 32'd217) begin
            failures++; $display("FAIL reset_abort got=%h cpb=%h required=00000001/000000d9", rd, cpb);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd; logic er; logic [7:0] d, exp_d; logic exp_e;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0: begin
                    d = 5'($urandom);
                    apb(32'h10, 1, 32'(d), rd, er); ctrl_m = d[4:0];
                end
                1, 2: begin
                    d = 8'($urandom);
                    exp_e = (txq.size() == DEPTH);
                    apb(32'h04, 1, 32'(d), rd, er);
                    if (!exp_e) txq.push_back(d);
                    checks++;
                    if (er !== exp_e) begin
                        failures++; $display("FAIL rnd_tdr_err got=%b required=%b", er, exp_e);
                    end
                end
                3: begin
                    exp_e = (rxq.size() == 0);
                    exp_d = exp_e ? 8'h0 : rxq.pop_front();
                    apb(32'h08, 0, 0, rd, er);
                    checks++;
                    if (rd !== 32'(exp_d) || er !== exp_e) begin
                        failures++; $display("FAIL rnd_rdr got=%h err=%b required=%h err=%b", rd, er, exp_d, exp_e);
                    end
                end
                4: begin
                    apb(32'h00, 0, 0, rd, er);
                    checks++;
                    if (rd !== exp_status()) begin
                        failures++; $display("FAIL rnd_status got=%h required=%h", rd, exp_status());
                    end
                end
                5, 6: core_push(8'($urandom));
                7, 8: begin
                    checks++;
                    if (tx_valid !== (ctrl_m[0] && txq.size() != 0) ||
                        (txq.size() != 0 && tx_data !== txq[0])) begin
                        failures++; $display("FAIL rnd_tx_head valid=%b data=%h required_size=%0d", tx_valid, tx_data, txq.size());
                    end
                    core_pop();
                end
                default: begin
                    d = 8'($urandom_range(0, 7));
                    apb(32'h14, 1, 32'(d), rd, er);
                    if (d[0]) ovr_m = 1'b0;
                    if (d[1]) txq.delete();
                    if (d[2]) rxq.delete();
                end
            endcase
            tick();
            checks++;
            if (irq !== exp_irq()) begin
                failures++; $display("FAIL rnd_irq op=%0d got=%b required=%b", n, irq, exp_irq());
            end
        end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_full();
        test_rx_overrun();
        test_clr_race();
        test_misc_regs();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_apb_fifo_regs.md
UART_APB_FIFO_REGS -- requirements
Module: uart_apb_fifo_regs

Interface
REQ-001 SHALL have parameter DATA_W, default 8, UART character width (5..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, entries per TX and RX FIFO (power of two, >=2); CNT_W = log2(FIFO_DEPTH)+1.
REQ-003 SHALL have parameter CPB_RESET, default 217, reset value of CLKS_PER_BIT.
REQ-004 SHALL have ports, in order: PCLK in 1 clock; PRESET in 1 reset, synchronous, active-high; PADDR in 32; PSEL in 1; PENABLE in 1; PWRITE in 1; PWDATA in 32; PRDATA out 32; PREADY out 1; PSLVERR out 1.
REQ-005 SHALL have ports: tx_data out DATA_W TX FIFO head; tx_valid out 1 TX FIFO non-empty and TX_EN; tx_ready in 1 core pops head; rx_data in DATA_W; rx_valid in 1 core pushes rx_data; cpb out 32; tx_en out 1; rx_en out 1; irq out 1.

Function
REQ-006 SHALL decode PADDR[4:0]: 0x00 STATUS RO, 0x04 TDR WO, 0x08 RDR RO, 0x0C CPB RW, 0x10 CTRL RW, 0x14 CLR W1C.
REQ-007 SHALL tie PREADY to 1; every transfer completes in 2 cycles (setup + access).
REQ-008 SHALL register PRDATA on the setup phase (PSEL & ~PENABLE & ~PWRITE), holding it through access; PRDATA SHALL be 0 in every other cycle and for unmapped/write-only addresses.
REQ-009 STATUS SHALL read {8'h0, rx_cnt[7:0], tx_cnt[7:0], 3'b0, OVR, RXF, RXNE, TXF, TXE}, counts zero-extended/truncated to 8 bits.
REQ-010 CTRL SHALL be bits {OVR_IE[4], RXNE_IE[3], TXE_IE[2], RX_EN[1], TX_EN[0]}; upper bits read 0.
REQ-011 A write access (PSEL & PENABLE & PWRITE) to TDR SHALL push PWDATA[DATA_W-1:0] into TX FIFO when not full.
REQ-012 A read access (PSEL & PENABLE & ~PWRITE) to RDR SHALL pop RX FIFO exactly once; PRDATA carries the head as captured in setup, zero-extended.
REQ-013 PSLVERR SHALL assert only in the access cycle for: TDR write with TX full (data dropped), RDR read with RX empty (PRDATA 0, no pop), unmapped address, write to STATUS/RDR; no state change on error.
REQ-014 Core pop SHALL occur when tx_valid & tx_ready; tx_data SHALL be the head combinationally from FIFO storage.
REQ-015 Core push SHALL occur when rx_valid & RX_EN; when RX full, data SHALL be dropped and sticky OVR set.
REQ-016 Full/empty for push acceptance SHALL use pre-cycle occupancy: push into a full FIFO is rejected even with simultaneous pop; simultaneous push and pop on a non-empty, non-full FIFO SHALL leave count unchanged.
REQ-017 Read/write pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-018 Writing CLR bit0 = 1 SHALL clear OVR; an overrun in the same cycle SHALL win (OVR stays 1).
REQ-019 Writing CLR bit1 = 1 SHALL flush TX FIFO, bit2 = 1 SHALL flush RX FIFO (pointers and count to 0) in that cycle, overriding any same-cycle push/pop.
REQ-020 irq SHALL be registered: irq <= (TXE_IE & TXE) | (RXNE_IE & RXNE) | (OVR_IE & OVR), one cycle latency.
REQ-021 cpb, tx_en, rx_en SHALL drive directly from CPB, CTRL[0], CTRL[1] registers.

Reset
REQ-022 On PCLK edge with PRESET=1: PRDATA=0, PSLVERR=0, irq=0, CPB=CPB_RESET, CTRL=0, OVR=0, both FIFOs empty (TXE=1, RXNE=0); FIFO storage need not clear.
REQ-023 Reset mid-transfer SHALL abort it with no push/pop; the next transfer after release behaves normally.

Verification
REQ-024 After reset, read 0x00 -> PRDATA 0x00000001; read 0x0C -> 217; PSLVERR 0.
REQ-025 CTRL=0x1, write TDR 0xA5, 0x3C with tx_ready=0 -> tx_valid=1, tx_data 0xA5, STATUS tx_cnt=2; one tx_ready cycle -> tx_data 0x3C.
REQ-026 Write 17 bytes to TDR (depth 16, tx_en 0) -> 17th write PSLVERR=1, TXF=1, tx_cnt=16; flush via CLR=0x2 -> TXE=1.
REQ-027 CTRL=0x12, push 17 bytes on rx_valid -> OVR=1, irq=1 one cycle later; 16 RDR reads return first 16 bytes in order; 17th read PSLVERR=1, PRDATA 0.
REQ-028 Write CLR=0x1 in same cycle as overflowing rx push -> OVR remains 1; next CLR=0x1 with no push -> OVR=0, irq falls next cycle.
REQ-029 Read 0x1C -> PSLVERR=1, PRDATA 0; write 0x0C 0x00000364 -> cpb=0x364.
